ibex_instr_mem_responder: RTL and testbench
===========================================

Name: ibex_instr_mem_responder

Overview:
- Memory-side responder for the core's 32-bit instruction fetch bus (req/gnt/rvalid protocol). It answers prefetch-buffer requests from a word-addressed instruction store.
- Grants requests, queues them in order, and returns rdata/err after a programmable latency. Supports multiple outstanding requests.
- Provides a backdoor load port for program images and a stall input for back-pressure testing.
- Used in simulation benches and small FPGA configurations in front of the fetch unit.

Parameters:
- MemWords, 1024, number of 32-bit words in the store (power of two, at least 4).
- MemBase, 32'h0000_0000, byte base address of the store (aligned to MemWords*4).
- MaxOutstanding, 2, response queue depth (1..4).
- RespLatency, 1, minimum cycles from grant to rvalid (1..7).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  byte address (bits [1:0] ignored)
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid
- instr_rdata_o  out  32  response data
- instr_err_o  out  1  response is a bus error
- stall_i  in  1  withhold grants while high
- load_we_i  in  1  backdoor word write
- load_addr_i  in  $clog2(MemWords)  backdoor word index
- load_wdata_i  in  32  backdoor write data
- busy_o  out  1  any request outstanding
- outstanding_o  out  3  current queue occupancy

Behaviour:
- Reset (rst_i high at a clock edge):
  - Queue is emptied and all in-flight responses are dropped.
  - Outputs after reset: gnt=0, rvalid=0, rdata=0, err=0, busy=0, outstanding=0.
  - Store contents are not reset.
  - Reset asserted mid-transaction: no rvalid is ever produced for requests granted before the reset.
- Grant is combinational: instr_gnt_o = instr_req_i & ~stall_i & (count < MaxOutstanding) & ~rst_i.
  - The count used for a grant decision does not include a pop happening in the same cycle, so a full queue never grants.
- On a grant, a queue entry is pushed containing:
  - data: the store word as of that cycle (a same-cycle load to the same word returns the old value);
  - err: set if the address is outside [MemBase, MemBase+MemWords*4);
  - countdown: initialised to RespLatency.
- Error responses return rdata=0 and err=1.
- Every valid entry's countdown decrements by 1 per cycle and saturates at 0.
- Responses:
  - The head entry responds (rvalid=1 for exactly one cycle) when its countdown is 0, then pops.
  - Strictly in order, at most one rvalid per cycle. Younger entries that reach 0 wait for the head.
  - A grant at cycle T produces its earliest rvalid at cycle T+RespLatency.
- When rvalid=0: rdata=0 and err=0.
- Occupancy: count_next = count + gnt - pop. A push and a pop in the same cycle are legal and leave the count unchanged.
- busy_o = (count != 0). outstanding_o = count.
- Queue pointers wrap modulo MaxOutstanding.
- Ungranted request (stall or full): the requester must hold req and addr stable. The responder does not latch an ungranted address. A request dropped before grant has no effect.
- Backdoor write: load_we_i writes the word at the clock edge. It may occur in any cycle, including during reset.

Optional Feature:
- Macro INSTR_MEM_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - Grants are additionally withheld when lfsr[1:0]==2'b00.
  - The LFSR holds its seed while rst_i is high.
- Undefined: no LFSR is built; grants depend only on stall_i, occupancy and reset.

Test Plan:
- Single fetch: load word 0x10 = 32'hDEAD_BEEF; req addr 32'h40 with RespLatency=1 → gnt at cycle T, rvalid at T+1 with rdata=32'hDEAD_BEEF, err=0, busy drops at T+2.
- Back-to-back fetch: continuous req to 0x0,0x4,0x8 with MaxOutstanding=2, RespLatency=3 → gnt in two consecutive cycles, third gnt withheld until first rvalid; responses in address order, outstanding_o peaks at 2.
- Out-of-range error: req addr MemWords*4 (32'h1000 at default) → gnt, rvalid with err=1, rdata=0.
- Stall: stall_i high for 5 cycles while req held at 32'h8 → gnt=0 for those cycles; gnt on the first cycle stall_i is low; data correct.
- Reset mid-flight: two requests granted, rst_i pulsed before either rvalid → no rvalid ever appears for them; outstanding_o=0 on the cycle after reset; a new request afterwards completes normally.
- Load/grant collision: load_we_i writes 32'h1111_1111 to word 2 in the same cycle addr 32'h8 is granted (old value 32'h2222_2222) → response returns 32'h2222_2222; next fetch of 32'h8 returns 32'h1111_1111.

Source files
------------

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch memory responder: grants req/gnt/rvalid fetches and answers them in order
// after a fixed latency. Define INSTR_MEM_RANDOM_STALL_EN to add LFSR-driven grant withholding.
module ibex_instr_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned RespLatency    = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_req_i,
    input  logic [31:0]                 instr_addr_i,
    output logic                        instr_gnt_o,
    output logic                        instr_rvalid_o,
    output logic [31:0]                 instr_rdata_o,
    output logic                        instr_err_o,
    input  logic                        stall_i,
    input  logic                        load_we_i,
    input  logic [$clog2(MemWords)-1:0] load_addr_i,
    input  logic [31:0]                 load_wdata_i,
    output logic                        busy_o,
    output logic [2:0]                  outstanding_o
);

    localparam int unsigned AW = $clog2(MemWords);
    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [31:0]               mem_q [MemWords];
    logic [31:0]               q_data_q [MaxOutstanding];
    logic                      q_err_q [MaxOutstanding];
    logic [2:0]                q_cnt_q [MaxOutstanding];
    logic [MaxOutstanding-1:0] q_valid_q;
    logic [PW-1:0]             head_q, tail_q;
    logic [2:0]                count_q, count_d;

    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          rand_ok;
    logic          gnt;
    logic          pop;
    logic          unused_offset;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef INSTR_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign rand_ok = (lfsr_q[1:0] != 2'b00);
`else
    assign rand_ok = 1'b1;
`endif

    assign offset        = instr_addr_i - MemBase;
    assign in_range      = (offset[31:AW+2] == '0);
    assign word_idx      = offset[AW+1:2];
    assign unused_offset = ^offset[1:0];

    // Occupancy excludes a same-cycle pop, so a full queue never grants.
    assign gnt = instr_req_i & ~stall_i & (count_q < 3'(MaxOutstanding)) & ~rst_i & rand_ok;
    assign pop = q_valid_q[head_q] & (q_cnt_q[head_q] == 3'd0) & ~rst_i;

    assign count_d = count_q + {2'b00, gnt} - {2'b00, pop};

    always_comb begin
        instr_gnt_o    = gnt;
        instr_rvalid_o = pop;
        instr_rdata_o  = pop ? q_data_q[head_q] : 32'h0;
        instr_err_o    = pop ? q_err_q[head_q] : 1'b0;
        busy_o         = (count_q != 3'd0);
        outstanding_o  = count_q;
    end

    // Backdoor loads are honoured even during reset; the store itself is never cleared.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 3'd0;
            q_valid_q <= '0;
        end else begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                if (q_valid_q[i] && q_cnt_q[i] != 3'd0) begin
                    q_cnt_q[i] <= q_cnt_q[i] - 3'd1;
                end
            end
            if (pop) begin
                q_valid_q[head_q] <= 1'b0;
                head_q            <= ptr_inc(head_q);
            end
            // The grant cycle is the first latency tick, hence RespLatency-1 stored.
            if (gnt) begin
                q_data_q[tail_q]  <= in_range ? mem_q[word_idx] : 32'h0;
                q_err_q[tail_q]   <= ~in_range;
                q_cnt_q[tail_q]   <= 3'(RespLatency - 1);
                q_valid_q[tail_q] <= 1'b1;
                tail_q            <= ptr_inc(tail_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder: a default instance (latency 1) and a latency-3 instance,
// each with a scoreboard that predicts responses from a model of the store.
module tb_ibex_instr_mem_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_wdata;

    logic        a_req, a_stall, a_gnt, a_rvalid, a_err, a_busy;
    logic [31:0] a_addr, a_rdata;
    logic [2:0]  a_out;
    logic        b_req, b_stall, b_gnt, b_rvalid, b_err, b_busy;
    logic [31:0] b_addr, b_rdata;
    logic [2:0]  b_out;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [31:0] model [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (load_we) model[load_addr] <= load_wdata;

    ibex_instr_mem_responder u_dut_a (
        .clk_i(clk), .rst_i(rst), .instr_req_i(a_req), .instr_addr_i(a_addr),
        .instr_gnt_o(a_gnt), .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata),
        .instr_err_o(a_err), .stall_i(a_stall), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .busy_o(a_busy), .outstanding_o(a_out)
    );

    ibex_instr_mem_responder #(.RespLatency(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .instr_req_i(b_req), .instr_addr_i(b_addr),
        .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata),
        .instr_err_o(b_err), .stall_i(b_stall), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .busy_o(b_busy), .outstanding_o(b_out)
    );

    function automatic logic [32:0] expect_word(input logic [31:0] addr);
        if (addr >= 32'h1000) return {1'b1, 32'h0};
        return {1'b0, model[addr[11:2]]};
    endfunction

    // Scoreboard for instance A (latency 1, depth 2).
    always @(negedge clk) begin
        exp_t h;
        logic [32:0] e;
        if (rst) begin
            n_checks++;
            if (a_gnt !== 1'b0 || a_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL a_rst_quiet: gnt=%b rvalid=%b required 0 0", a_gnt, a_rvalid);
            end
            qa.delete();
        end else begin
            n_checks++;
            if (a_out !== 3'(qa.size()) || a_busy !== (qa.size() != 0)) begin
                n_fail++; $display("FAIL a_occupancy: out=%0d busy=%b required %0d", a_out, a_busy, qa.size());
            end
            if (a_gnt) begin
                n_checks++;
                if (!a_req || a_stall || qa.size() >= 2) begin
                    n_fail++; $display("FAIL a_gnt_illegal: gnt=1 req=%b stall=%b occ=%0d", a_req, a_stall, qa.size());
                end
                e = expect_word(a_addr);
                qa.push_back('{e[31:0], e[32], cyc});
            end
            n_checks++;
            if (a_rvalid) begin
                h = qa.pop_front();
                if ({a_err, a_rdata} !== {h.err, h.data} || cyc - h.cyc < 1) begin
                    n_fail++; $display("FAIL a_resp: got err=%b data=%h required err=%b data=%h (lat %0d)", a_err, a_rdata, h.err, h.data, cyc - h.cyc);
                end
            end else if (a_rdata !== 32'h0 || a_err !== 1'b0) begin
                n_fail++; $display("FAIL a_idle_outputs: data=%h err=%b required 0", a_rdata, a_err);
            end
        end
    end

    // Scoreboard for instance B (latency 3, depth 2).
    always @(negedge clk) begin
        exp_t h;
        logic [32:0] e;
        if (rst) begin
            n_checks++;
            if (b_gnt !== 1'b0 || b_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL b_rst_quiet: gnt=%b rvalid=%b required 0 0", b_gnt, b_rvalid);
            end
            qb.delete();
        end else begin
            n_checks++;
            if (b_out !== 3'(qb.size()) || b_busy !== (qb.size() != 0)) begin
                n_fail++; $display("FAIL b_occupancy: out=%0d busy=%b required %0d", b_out, b_busy, qb.size());
            end
            if (b_gnt) begin
                n_checks++;
                if (!b_req || b_stall || qb.size() >= 2) begin
                    n_fail++; $display("FAIL b_gnt_illegal: gnt=1 req=%b occ=%0d", b_req, qb.size());
                end
                e = expect_word(b_addr);
                qb.push_back('{e[31:0], e[32], cyc});
            end
            n_checks++;
            if (b_rvalid) begin
                h = qb.pop_front();
                if ({b_err, b_rdata} !== {h.err, h.data} || cyc - h.cyc < 3) begin
                    n_fail++; $display("FAIL b_resp: got err=%b data=%h required err=%b data=%h (lat %0d)", b_err, b_rdata, h.err, h.data, cyc - h.cyc);
                end
            end else if (b_rdata !== 32'h0 || b_err !== 1'b0) begin
                n_fail++; $display("FAIL b_idle_outputs: data=%h err=%b required 0", b_rdata, b_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] val);
        load_we = 1'b1; load_addr = idx; load_wdata = val;
        tick();
        load_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_req = 1'b1; a_addr = 32'h0;
        tick();
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b required 0", a_gnt); end
        tick();
        a_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_gnt, a_rvalid, a_rdata, a_err, a_busy, a_out} !== 39'h0 || b_out !== 3'd0) begin
            n_fail++; $display("FAIL reset_outputs: gnt=%b rv=%b data=%h err=%b busy=%b out=%0d required all 0",
                               a_gnt, a_rvalid, a_rdata, a_err, a_busy, a_out);
        end
    endtask

    task automatic test_single_fetch();
        load(10'h10, 32'hDEAD_BEEF);
        a_req = 1'b1; a_addr = 32'h40;
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL single_gnt: got %b required 1", a_gnt); end
        tick();
        a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF || a_err !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_resp: rv=%b data=%h err=%b busy=%b required 1 deadbeef 0 1", a_rvalid, a_rdata, a_err, a_busy);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0 || a_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: busy=%b rv=%b required 0 0", a_busy, a_rvalid);
        end
    endtask

    task automatic test_error();
        load(10'h3FF, 32'h5A5A_A5A5);
        a_req = 1'b1; a_addr = 32'hFFC;
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL err_gnt_last: got %b required 1", a_gnt); end
        tick();
        a_addr = 32'h1000;
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== 32'h5A5A_A5A5 || a_err !== 1'b0) begin
            n_fail++; $display("FAIL err_last_word: gnt=%b rv=%b data=%h err=%b required 1 1 5a5aa5a5 0", a_gnt, a_rvalid, a_rdata, a_err);
        end
        tick();
        a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0 || a_err !== 1'b1) begin
            n_fail++; $display("FAIL err_resp: rv=%b data=%h err=%b required 1 0 1", a_rvalid, a_rdata, a_err);
        end
        tick();
    endtask

    task automatic test_stall();
        load(10'h2, 32'h2222_2222);
        a_stall = 1'b1; a_req = 1'b1; a_addr = 32'h8;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b required 0", k, a_gnt); end
            tick();
        end
        a_stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL stall_release_gnt: got %b required 1", a_gnt); end
        tick();
        a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h2222_2222) begin
            n_fail++; $display("FAIL stall_resp: rv=%b data=%h required 1 22222222", a_rvalid, a_rdata);
        end
        tick();
    endtask

    task automatic test_collision();
        a_req = 1'b1; a_addr = 32'h8;
        load_we = 1'b1; load_addr = 10'h2; load_wdata = 32'h1111_1111;
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL coll_gnt: got %b required 1", a_gnt); end
        tick();
        load_we = 1'b0; a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h2222_2222) begin
            n_fail++; $display("FAIL coll_old: rv=%b data=%h required 1 22222222", a_rvalid, a_rdata);
        end
        tick();
        a_req = 1'b1;
        @(negedge clk);
        tick();
        a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h1111_1111) begin
            n_fail++; $display("FAIL coll_new: rv=%b data=%h required 1 11111111", a_rvalid, a_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0]  eg;
        logic [8:0]  ev;
        int          eo[9];
        logic [31:0] got[3];
        int          nr;
        eg = 9'b000010011;
        ev = 9'b010011000;
        eo = '{0, 1, 2, 2, 1, 1, 1, 1, 0};
        nr = 0;
        for (int w = 0; w < 3; w++) load(10'(w), 32'hB0B0_0000 + 32'(w));
        b_req = 1'b1; b_addr = 32'h0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (b_gnt !== eg[k] || b_rvalid !== ev[k] || b_out !== 3'(eo[k])) begin
                n_fail++; $display("FAIL b2b_cycle[%0d]: gnt=%b rv=%b out=%0d required %b %b %0d",
                                   k, b_gnt, b_rvalid, b_out, eg[k], ev[k], eo[k]);
            end
            if (b_rvalid && nr < 3) begin got[nr] = b_rdata; nr++; end
            tick();
            if (k == 0) b_addr = 32'h4;
            else if (k < 4) b_addr = 32'h8;
            else b_req = 1'b0;
        end
        for (int w = 0; w < 3; w++) begin
            n_checks++;
            if (w >= nr || got[w] !== 32'hB0B0_0000 + 32'(w)) begin
                n_fail++; $display("FAIL b2b_order[%0d]: got %h (of %0d) required %h", w, got[w], nr, 32'hB0B0_0000 + 32'(w));
            end
        end
    endtask

    task automatic test_reset_midflight();
        b_req = 1'b1; b_addr = 32'h0;
        @(negedge clk);
        tick();
        b_addr = 32'h4;
        @(negedge clk);
        n_checks++;
        if (b_out !== 3'd1 || b_gnt !== 1'b1) begin
            n_fail++; $display("FAIL midrst_setup: out=%0d gnt=%b required 1 1", b_out, b_gnt);
        end
        tick();
        b_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (b_rvalid !== 1'b0 || b_out !== 3'd0) begin
                n_fail++; $display("FAIL midrst_drop[%0d]: rv=%b out=%0d required 0 0", k, b_rvalid, b_out);
            end
            tick();
        end
        b_req = 1'b1; b_addr = 32'h4;
        @(negedge clk);
        tick();
        b_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (b_rvalid !== (k == 3) || (k == 3 && b_rdata !== 32'hB0B0_0001)) begin
                n_fail++; $display("FAIL midrst_after[%0d]: rv=%b data=%h required %b b0b00001", k, b_rvalid, b_rdata, k == 3);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_wdata = '0;
        a_req = 1'b0; a_addr = '0; a_stall = 1'b0;
        b_req = 1'b0; b_addr = '0; b_stall = 1'b0;
        test_reset();
        test_single_fetch();
        test_error();
        test_stall();
        test_collision();
        test_back_to_back();
        test_reset_midflight();
        repeat (3) tick();
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++; $display("FAIL drain: a left %0d b left %0d required 0", qa.size(), qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
